// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch PC sequencer with an IF/ID pipeline register.
//
// Sequences fetch_pc through BOOT -> RUN, holding in MISS while the I-cache
// misses. Exceptions, taken redirects, miss holds and decode stalls are
// resolved in a fixed priority order.
//
// Ports:
//   clk            single clock, rising-edge
//   rst            synchronous active-high reset
//   ihit           I-cache hit for the current fetch_pc (same cycle)
//   stall          decode hazard; IF/ID holds
//   redirect_valid taken branch/jump this cycle
//   redirect_pc    branch/jump target (low two bits ignored)
//   exc            exception request
//   fetch_pc       address presented to the I-cache (word aligned)
//   fetch_req      fetch_pc is a live request
//   if_valid       IF/ID holds a valid instruction
//   if_pc          PC of the instruction in IF/ID
//   epc            fetch_pc captured when an exception was taken
//   miss_cnt       saturating count of cycles spent in MISS
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ihit,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc,
  output logic [31:0] fetch_pc,
  output logic        fetch_req,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] epc,
  output logic [15:0] miss_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    MISS = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] epc_q, epc_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  // State register. Reset discards everything, including a pending miss or
  // a held IF/ID, so the block always restarts with one BOOT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      epc_q      <= 32'h0;
      miss_cnt_q <= 16'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      epc_q      <= epc_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Next-state logic. Priority in RUN/MISS: exception, then redirect, then
  // miss/stall hold, then sequential advance. A hit while in MISS behaves
  // exactly like a hit in RUN.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    epc_d      = epc_q;
    miss_cnt_d = miss_cnt_q;

    // Every cycle spent in MISS is counted, saturating at all-ones.
    if (state_q == MISS && miss_cnt_q != 16'hFFFF) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN, MISS: begin
        if (exc) begin
          fetch_pc_d = EXC_VEC;
          epc_d      = fetch_pc_q;
          if_valid_d = 1'b0;
          state_d    = RUN;
        end else if (redirect_valid) begin
          // Squashes IF/ID even under stall and abandons any miss.
          fetch_pc_d = {redirect_pc[31:2], 2'b00};
          if_valid_d = 1'b0;
          state_d    = RUN;
        end else if (!ihit) begin
          state_d = MISS;
          if (!stall) begin
            if_valid_d = 1'b0;
          end
        end else begin
          state_d = RUN;
          if (!stall) begin
            if_valid_d = 1'b1;
            if_pc_d    = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign fetch_pc  = {fetch_pc_q[31:2], 2'b00};
  assign fetch_req = (state_q != BOOT);
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign epc       = epc_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl. Inputs change and outputs
// are sampled on the falling edge, half a cycle away from the active edge.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ihit;
  logic        stall;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        exc;
  logic [31:0] fetchPc;
  logic        fetchReq;
  logic        ifValid;
  logic [31:0] ifPc;
  logic [31:0] epc;
  logic [15:0] missCnt;

  int passCnt  = 0;
  int failCnt  = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .ihit           (ihit),
    .stall          (stall),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .exc            (exc),
    .fetch_pc       (fetchPc),
    .fetch_req      (fetchReq),
    .if_valid       (ifValid),
    .if_pc          (ifPc),
    .epc            (epc),
    .miss_cnt       (missCnt)
  );

  // Set all inputs for the coming rising edge.
  task automatic applyStimulus(input logic r, input logic h, input logic s,
                               input logic rv, input logic [31:0] rp,
                               input logic e);
    rst           = r;
    ihit          = h;
    stall         = s;
    redirectValid = rv;
    redirectPc    = rp;
    exc           = e;
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAllReset(input string tag);
    checkOutput({tag, "_fetch_pc"}, fetchPc, 32'h0);
    checkOutput({tag, "_fetch_req"}, {31'h0, fetchReq}, 32'h0);
    checkOutput({tag, "_if_valid"}, {31'h0, ifValid}, 32'h0);
    checkOutput({tag, "_if_pc"}, ifPc, 32'h0);
    checkOutput({tag, "_epc"}, epc, 32'h0);
    checkOutput({tag, "_miss_cnt"}, {16'h0, missCnt}, 32'h0);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    tick();
    tick();
    checkAllReset("reset");

    // Release reset; exc/redirect during the BOOT cycle must be ignored.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0500, 1'b1);
    checkOutput("boot_fetch_req", {31'h0, fetchReq}, 32'h0);
    tick();
    checkOutput("boot_exit_fetch_req", {31'h0, fetchReq}, 32'h1);
    checkOutput("boot_exit_fetch_pc", fetchPc, 32'h0);
    checkOutput("boot_exit_epc", epc, 32'h0);
    checkOutput("boot_exit_if_valid", {31'h0, ifValid}, 32'h0);

    // Sequential fetch: if_pc lags fetch_pc by one word.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput("seq_fetch_pc", fetchPc, 32'(i * 4));
      checkOutput("seq_if_pc", ifPc, 32'((i - 1) * 4));
      checkOutput("seq_if_valid", {31'h0, ifValid}, 32'h1);
    end

    // Three miss cycles at 0x10, then a hit.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("miss_fetch_pc", fetchPc, 32'h10);
      checkOutput("miss_if_valid", {31'h0, ifValid}, 32'h0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("miss_cnt_after", {16'h0, missCnt}, 32'h3);
    checkOutput("miss_hit_if_pc", ifPc, 32'h10);
    checkOutput("miss_hit_if_valid", {31'h0, ifValid}, 32'h1);
    checkOutput("miss_hit_fetch_pc", fetchPc, 32'h14);

    // Stall on a hit holds fetch_pc and IF/ID.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("stall_fetch_pc", fetchPc, 32'h14);
    checkOutput("stall_if_pc", ifPc, 32'h10);
    checkOutput("stall_if_valid", {31'h0, ifValid}, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("pre_redir_fetch_pc", fetchPc, 32'h20);

    // Miss at 0x20 abandoned by a redirect to an unaligned target.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0);
    tick();
    checkOutput("redir_fetch_pc", fetchPc, 32'h100);
    checkOutput("redir_if_valid", {31'h0, ifValid}, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("redir_next_if_pc", ifPc, 32'h100);
    checkOutput("redir_next_fetch_pc", fetchPc, 32'h104);

    // Exception beats redirect and stall at 0x40.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
    tick();
    checkOutput("to40_fetch_pc", fetchPc, 32'h40);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
    tick();
    checkOutput("exc_fetch_pc", fetchPc, 32'h80);
    checkOutput("exc_epc", epc, 32'h40);
    checkOutput("exc_if_valid", {31'h0, ifValid}, 32'h0);

    // Wrap at the top of the address space.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    checkOutput("wrap_fetch_pc0", fetchPc, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("wrap_fetch_pc1", fetchPc, 32'h0);
    checkOutput("wrap_if_pc", ifPc, 32'hFFFF_FFFC);
    checkOutput("wrap_if_valid", {31'h0, ifValid}, 32'h1);

    // Redirect squashes IF/ID even while stalled.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b0);
    tick();
    checkOutput("squash_if_valid", {31'h0, ifValid}, 32'h0);
    checkOutput("squash_fetch_pc", fetchPc, 32'h300);

    // Reset in the middle of a miss.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 1'b1);
    tick();
    checkAllReset("midmiss_reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("post_reset_fetch_req", {31'h0, fetchReq}, 32'h1);
    checkOutput("post_reset_if_valid", {31'h0, ifValid}, 32'h0);
    checkOutput("post_reset_fetch_pc", fetchPc, 32'h0);
    tick();
    checkOutput("post_reset_run_if_pc", ifPc, 32'h0);
    checkOutput("post_reset_run_if_valid", {31'h0, ifValid}, 32'h1);
    checkOutput("post_reset_run_fetch_pc", fetchPc, 32'h4);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter EXC_VEC, default 32'h0000_0080, meaning the exception handler fetch address.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ihit  input  1  I-cache hit for the current fetch_pc, valid in the same cycle.
REQ-006 SHALL have port stall  input  1  decode hazard; IF/ID must hold.
REQ-007 SHALL have port redirect_valid  input  1  resolved branch/jump, taken this cycle.
REQ-008 SHALL have port redirect_pc  input  32  branch/jump target.
REQ-009 SHALL have port exc  input  1  exception request.
REQ-010 SHALL have port fetch_pc  output  32  address presented to the I-cache.
REQ-011 SHALL have port fetch_req  output  1  fetch_pc is a live request.
REQ-012 SHALL have port if_valid  output  1  IF/ID holds a valid instruction.
REQ-013 SHALL have port if_pc  output  32  PC of the instruction in IF/ID.
REQ-014 SHALL have port epc  output  32  captured exception PC.
REQ-015 SHALL have port miss_cnt  output  16  count of I-cache miss cycles.

Function
REQ-016 SHALL implement FSM states BOOT, RUN and MISS; fetch_req SHALL be 0 in BOOT and 1 in RUN and MISS.
REQ-017 BOOT SHALL go to RUN after exactly one cycle, ignoring exc, redirect_valid, stall and ihit.
REQ-018 In RUN and MISS, next-PC priority SHALL be: exc > redirect_valid > miss/stall hold > sequential.
REQ-019 On exc: fetch_pc <= EXC_VEC; epc <= fetch_pc; if_valid <= 0; state <= RUN.
REQ-020 On redirect_valid (no exc): fetch_pc <= {redirect_pc[31:2], 2'b00}; if_valid <= 0; state <= RUN; this SHALL also abandon a MISS.
REQ-021 In RUN, if ihit=0 (no exc or redirect): state <= MISS; fetch_pc holds; if_valid <= 0 unless stall=1, in which case IF/ID holds.
REQ-022 In MISS: fetch_pc holds; miss_cnt increments each cycle, saturating at 16'hFFFF; when ihit=1, behaviour SHALL match the RUN hit case in the same cycle and state <= RUN.
REQ-023 On a hit with stall=0: if_valid <= 1; if_pc <= fetch_pc; fetch_pc <= fetch_pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-024 On a hit with stall=1: fetch_pc, if_valid and if_pc SHALL hold.
REQ-025 On a miss with stall=0: if_valid <= 0.
REQ-026 Latency: an instruction hitting in cycle N SHALL appear on if_valid/if_pc in cycle N+1.
REQ-027 redirect_valid SHALL override stall: IF/ID is squashed even while stalled.
REQ-028 fetch_pc[1:0] SHALL always be 2'b00.

Reset
REQ-029 While rst=1 at a clock edge: fetch_pc=RESET_PC, state=BOOT, fetch_req=0, if_valid=0, if_pc=0, epc=0, miss_cnt=0; all other inputs ignored.
REQ-030 Reset asserted mid-MISS or mid-stall SHALL discard all pending state; the behaviour of REQ-017 applies after release.

Verification
REQ-031 Release rst, hold ihit=1, stall=0 -> BOOT 1 cycle with fetch_req=0; then fetch_pc 0,4,8,...; if_pc lags fetch_pc by one cycle with if_valid=1.
REQ-032 At fetch_pc=0x10, ihit=0 for 3 cycles then 1 -> fetch_pc holds 0x10; if_valid=0 for 3 cycles; miss_cnt=3; if_pc=0x10 the cycle after the hit.
REQ-033 During MISS at 0x20, redirect_valid=1 with redirect_pc=0x103 -> next fetch_pc=0x100; state RUN; if_valid=0; no instruction from 0x20 is delivered.
REQ-034 stall=1 and redirect_valid=1 with exc=1 in the same cycle at fetch_pc=0x40 -> fetch_pc=0x80, epc=0x40, if_valid=0.
REQ-035 redirect_pc=0xFFFF_FFFC with ihit=1 -> fetch_pc sequence 0xFFFF_FFFC then 0x0000_0000.
REQ-036 rst=1 for one edge mid-MISS with miss_cnt=5 -> all outputs at their reset values, including miss_cnt=0; one BOOT cycle follows.
